// File: rtl/demux1to16_capture.sv
// rtl/demux1to16_capture.sv - serial bit stream to 16-bit word assembler with valid/ready handshakes
//
// Purpose: accepts one serial bit per in_valid/in_ready handshake and places it
// into a 16-bit assembly register at the position given by sel. On the 16th
// accepted bit, the completed word is copied to out and presented with
// out_valid. The word is held until out_ready is seen. No new bits are taken
// while the word is held.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   in        - serial data bit
//   in_valid  - in carries a bit this cycle
//   in_ready  - block can accept a bit this cycle (low while a word is held)
//   clr       - synchronous abort of the partial or held word (out keeps its value)
//   sel       - index of the next bit to be accepted
//   out       - assembled word (changes only on completion, clr never touches it)
//   out_valid - out holds a complete word not yet taken
//   out_ready - consumer takes out this cycle
//   MSB_FIRST - 0: accepted bit k lands in out[k]; 1: lands in out[15-k]

module demux1to16_capture #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clr,
  output logic [3:0]  sel,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] asm_q, asm_d;
  logic [15:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;

  logic        accept;
  logic        last_bit;
  logic [3:0]  wr_idx;
  logic [15:0] asm_word;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (accept && last_bit) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q != FULL);
  end

  assign accept   = in_valid && in_ready;
  assign last_bit = (sel_q == 4'd15);
  assign wr_idx   = MSB_FIRST ? (4'd15 - sel_q) : sel_q;

  // Assembly register with the incoming bit merged in, used both for the
  // partial update and for the completed word on the 16th accept.
  always_comb begin
    asm_word         = asm_q;
    asm_word[wr_idx] = in;
  end

  // Datapath next values
  always_comb begin
    sel_d       = sel_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      sel_d       = 4'd0;
      asm_d       = 16'h0000;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        // sel wraps 15 -> 0 naturally in 4 bits
        sel_d = sel_q + 4'd1;
        if (last_bit) begin
          out_d       = asm_word;
          out_valid_d = 1'b1;
          asm_d       = 16'h0000;
        end else begin
          asm_d = asm_word;
        end
      end
      if ((state_q == FULL) && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q       <= 4'd0;
      asm_q       <= 16'h0000;
      out_q       <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
